// File: rtl/recon_dma_desc_arbiter.sv
// Round-robin arbiter sharing one DMA read-descriptor channel between PORTS requesters,
// with source-port tagging, an in-flight limit and completion status demultiplexing.
module recon_dma_desc_arbiter #(
  parameter int PORTS              = 2,
  parameter int ADDR_WIDTH         = 34,
  parameter int DMA_DESC_LEN_WIDTH = 20,
  parameter int S_TAG_WIDTH        = 5,
  parameter int DMA_DESC_TAG_WIDTH = 8,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]     s_axis_read_desc_addr,
  input  logic [PORTS*DMA_DESC_LEN_WIDTH-1:0] s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]    s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                s_axis_read_desc_valid,
  output logic [PORTS-1:0]                s_axis_read_desc_ready,
  output logic [ADDR_WIDTH-1:0]           m_axis_read_desc_addr,
  output logic [DMA_DESC_LEN_WIDTH-1:0]   m_axis_read_desc_len,
  output logic [DMA_DESC_TAG_WIDTH-1:0]   m_axis_read_desc_tag,
  output logic                            m_axis_read_desc_valid,
  input  logic                            m_axis_read_desc_ready,
  input  logic [DMA_DESC_TAG_WIDTH-1:0]   s_axis_read_desc_status_tag,
  input  logic [3:0]                      s_axis_read_desc_status_error,
  input  logic                            s_axis_read_desc_status_valid,
  output logic [PORTS*S_TAG_WIDTH-1:0]    m_axis_read_desc_status_tag,
  output logic [PORTS*4-1:0]              m_axis_read_desc_status_error,
  output logic [PORTS-1:0]                m_axis_read_desc_status_valid,
  output logic [7:0]                      stat_outstanding,
  output logic                            stat_unexpected
);

  localparam int PORT_W = $clog2(PORTS);
  localparam int UP_W   = DMA_DESC_TAG_WIDTH - S_TAG_WIDTH;

  if (DMA_DESC_TAG_WIDTH < S_TAG_WIDTH + PORT_W) begin : g_tag_width_check
    $error("DMA_DESC_TAG_WIDTH too small for S_TAG_WIDTH plus port index");
  end

  logic [PORT_W-1:0]             r_last_grant;
  logic [7:0]                    r_outstanding;
  logic                          r_unexpected;
  logic [ADDR_WIDTH-1:0]         r_m_addr;
  logic [DMA_DESC_LEN_WIDTH-1:0] r_m_len;
  logic [DMA_DESC_TAG_WIDTH-1:0] r_m_tag;
  logic                          r_m_valid;
  logic [PORTS*S_TAG_WIDTH-1:0]  r_st_tag;
  logic [PORTS*4-1:0]            r_st_err;
  logic [PORTS-1:0]              r_st_valid;

  logic                          w_slot_free;
  logic                          w_found;
  logic                          w_grant;
  logic [PORT_W-1:0]             w_sel;
  logic [PORTS-1:0]              w_ready;
  logic [DMA_DESC_TAG_WIDTH-1:0] w_new_tag;
  logic [UP_W-1:0]               w_st_upper;
  logic [PORT_W-1:0]             w_st_port;
  logic                          w_st_ok;
  logic                          w_dec;

  // Round-robin search starting one past the last granted port.
  always_comb begin : p_arb
    int unsigned v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    for (int k = 0; k < PORTS; k++) begin
      v_idx = (int'(r_last_grant) + 1 + k) % PORTS;
      if (!w_found && s_axis_read_desc_valid[v_idx]) begin
        w_found = 1'b1;
        w_sel   = PORT_W'(v_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_slot_free = !r_m_valid || m_axis_read_desc_ready;
  assign w_grant     = w_slot_free && (r_outstanding < 8'(MAX_OUTSTANDING)) && w_found;

  // One-hot grant and source-tagged descriptor for the selected port.
  always_comb begin
    w_ready   = '0;
    w_new_tag = '0;
    w_new_tag[S_TAG_WIDTH-1:0]      = s_axis_read_desc_tag[w_sel*S_TAG_WIDTH +: S_TAG_WIDTH];
    w_new_tag[S_TAG_WIDTH +: PORT_W] = w_sel;
    if (w_grant) begin
      w_ready[w_sel] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Everything above the port tag is the port index; nonzero padding makes it out of range.
  assign w_st_upper = s_axis_read_desc_status_tag[DMA_DESC_TAG_WIDTH-1:S_TAG_WIDTH];
  assign w_st_port  = w_st_upper[PORT_W-1:0];
  assign w_st_ok    = s_axis_read_desc_status_valid && ({1'b0, w_st_upper} < (UP_W+1)'(PORTS));
  assign w_dec      = w_st_ok && (r_outstanding != 8'd0);

  // Output descriptor register, in-flight count, round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_addr      <= '0;
      r_m_len       <= '0;
      r_m_tag       <= '0;
      r_m_valid     <= 1'b0;
      r_outstanding <= 8'd0;
      r_last_grant  <= PORT_W'(PORTS - 1);
    end else begin
      if (w_grant) begin
        r_m_addr     <= s_axis_read_desc_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
        r_m_len      <= s_axis_read_desc_len[w_sel*DMA_DESC_LEN_WIDTH +: DMA_DESC_LEN_WIDTH];
        r_m_tag      <= w_new_tag;
        r_m_valid    <= 1'b1;
        r_last_grant <= w_sel;
      end else if (r_m_valid && m_axis_read_desc_ready) begin
        r_m_addr  <= '0;
        r_m_len   <= '0;
        r_m_tag   <= '0;
        r_m_valid <= 1'b0;
      end
      case ({w_grant, w_dec})
        2'b10:   r_outstanding <= r_outstanding + 8'd1;
        2'b01:   r_outstanding <= r_outstanding - 8'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Completion demultiplexing and the sticky unexpected-completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_tag     <= '0;
      r_st_err     <= '0;
      r_st_valid   <= '0;
      r_unexpected <= 1'b0;
    end else begin
      r_st_valid <= '0;
      if (w_st_ok) begin
        r_st_valid[w_st_port]                         <= 1'b1;
        r_st_tag[w_st_port*S_TAG_WIDTH +: S_TAG_WIDTH] <= s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
        r_st_err[w_st_port*4 +: 4]                     <= s_axis_read_desc_status_error;
      end
      if (s_axis_read_desc_status_valid && (!w_st_ok || r_outstanding == 8'd0)) begin
        r_unexpected <= 1'b1;
      end
    end
  end

  assign s_axis_read_desc_ready        = w_ready;
  assign m_axis_read_desc_addr         = r_m_addr;
  assign m_axis_read_desc_len          = r_m_len;
  assign m_axis_read_desc_tag          = r_m_tag;
  assign m_axis_read_desc_valid        = r_m_valid;
  assign m_axis_read_desc_status_tag   = r_st_tag;
  assign m_axis_read_desc_status_error = r_st_err;
  assign m_axis_read_desc_status_valid = r_st_valid;
  assign stat_outstanding              = r_outstanding;
  assign stat_unexpected               = r_unexpected;

endmodule

// File: tb/tb_recon_dma_desc_arbiter.sv
// Directed and randomized bench for recon_dma_desc_arbiter against a transaction-level model.
module tb_recon_dma_desc_arbiter;
  localparam int PORTS = 2;
  localparam int AW    = 34;
  localparam int LW    = 20;
  localparam int STW   = 5;
  localparam int DTW   = 8;
  localparam int MAXO  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PORTS*AW-1:0]   s_addr;
  logic [PORTS*LW-1:0]   s_len;
  logic [PORTS*STW-1:0]  s_tag;
  logic [PORTS-1:0]      s_valid;
  logic [PORTS-1:0]      s_ready;
  logic [AW-1:0]         m_addr;
  logic [LW-1:0]         m_len;
  logic [DTW-1:0]        m_tag;
  logic                  m_valid;
  logic                  m_ready;
  logic [DTW-1:0]        st_tag;
  logic [3:0]            st_err;
  logic                  st_valid;
  logic [PORTS*STW-1:0]  o_st_tag;
  logic [PORTS*4-1:0]    o_st_err;
  logic [PORTS-1:0]      o_st_valid;
  logic [7:0]            outstanding;
  logic                  unexpected;

  always #5 clk = ~clk;

  recon_dma_desc_arbiter #(
    .PORTS(PORTS), .ADDR_WIDTH(AW), .DMA_DESC_LEN_WIDTH(LW),
    .S_TAG_WIDTH(STW), .DMA_DESC_TAG_WIDTH(DTW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_read_desc_addr(s_addr), .s_axis_read_desc_len(s_len),
    .s_axis_read_desc_tag(s_tag), .s_axis_read_desc_valid(s_valid),
    .s_axis_read_desc_ready(s_ready),
    .m_axis_read_desc_addr(m_addr), .m_axis_read_desc_len(m_len),
    .m_axis_read_desc_tag(m_tag), .m_axis_read_desc_valid(m_valid),
    .m_axis_read_desc_ready(m_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_error(st_err),
    .s_axis_read_desc_status_valid(st_valid),
    .m_axis_read_desc_status_tag(o_st_tag), .m_axis_read_desc_status_error(o_st_err),
    .m_axis_read_desc_status_valid(o_st_valid),
    .stat_outstanding(outstanding), .stat_unexpected(unexpected)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int                   mc;
  int                   mlast;
  bit                   munexp;
  bit                   mhv;
  logic [AW-1:0]        mha;
  logic [LW-1:0]        mhl;
  logic [DTW-1:0]       mht;
  logic [PORTS-1:0]     msv;
  logic [PORTS*STW-1:0] mst;
  logic [PORTS*4-1:0]   mse;
  logic [DTW-1:0]       inflight[$];
  logic [PORTS-1:0]     obs_ready;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if ((mhv && !m_ready) || mc >= MAXO) return -1;
    for (int k = 1; k <= PORTS; k++) begin
      int p;
      p = (mlast + k) % PORTS;
      if (s_valid[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mc = 0; mlast = PORTS - 1; munexp = 0; mhv = 0;
    mha = '0; mhl = '0; mht = '0; msv = '0; mst = '0; mse = '0;
    inflight.delete();
  endtask

  task automatic check_outputs();
    check("m_valid", 128'(m_valid), 128'(mhv));
    check("m_addr", 128'(m_addr), 128'(mha));
    check("m_len", 128'(m_len), 128'(mhl));
    check("m_tag", 128'(m_tag), 128'(mht));
    check("outstanding", 128'(outstanding), 128'(mc));
    check("unexpected", 128'(unexpected), 128'(munexp));
    check("st_valid", 128'(o_st_valid), 128'(msv));
    check("st_tag", 128'(o_st_tag), 128'(mst));
    check("st_err", 128'(o_st_err), 128'(mse));
  endtask

  // One clock: inputs already set at the falling edge; leaves at the next falling edge.
  task automatic step();
    int p;
    int up;
    bit ok;
    bit dec;
    logic [PORTS-1:0] er;
    #1;
    p  = pick();
    er = (p >= 0) ? (PORTS'(1) << p) : '0;
    obs_ready = s_ready;
    check("s_ready", 128'(s_ready), 128'(er));
    @(posedge clk);
    up  = int'(st_tag) >> STW;
    ok  = st_valid && (up < PORTS);
    dec = ok && (mc > 0);
    if (st_valid && (!ok || mc == 0)) munexp = 1;
    msv = '0;
    if (ok) begin
      msv[up] = 1'b1;
      mst[up*STW +: STW] = st_tag[STW-1:0];
      mse[up*4 +: 4]     = st_err;
    end
    if (p >= 0) begin
      mhv   = 1;
      mha   = s_addr[p*AW +: AW];
      mhl   = s_len[p*LW +: LW];
      mht   = DTW'(p * (1 << STW)) | DTW'(s_tag[p*STW +: STW]);
      mlast = p;
      mc++;
      inflight.push_back(mht);
    end else if (mhv && m_ready) begin
      mhv = 0; mha = '0; mhl = '0; mht = '0;
    end
    if (dec) mc--;
    #1;
    check_outputs();
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic set_status(input logic [DTW-1:0] t, input logic [3:0] e);
    st_tag = t; st_err = e; st_valid = 1'b1;
    for (int i = 0; i < inflight.size(); i++) begin
      if (inflight[i] == t) begin
        inflight.delete(i);
        break;
      end
    end
  endtask

  task automatic do_reset();
    s_valid = '0; st_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_addr = '0; s_len = '0; s_tag = '0; s_valid = '0;
    m_ready = 1'b0; st_tag = '0; st_err = '0; st_valid = 1'b0; obs_ready = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_outstanding", 128'(outstanding), 128'(0));

    // Single request on port 1
    s_addr[AW +: AW] = 34'h1_0000_0000;
    s_len[LW +: LW]  = 20'h00400;
    s_tag[STW +: STW] = 5'd3;
    s_addr[0 +: AW] = 34'h0_1234_5678;
    s_len[0 +: LW]  = 20'h00010;
    s_tag[0 +: STW] = 5'h0A;
    s_valid = 2'b10;
    step();
    s_valid = 2'b00;
    check("single_ready", 128'(obs_ready), 128'(2'b10));
    check("single_tag", 128'(m_tag), 128'(8'h23));
    check("single_addr", 128'(m_addr), 128'(34'h1_0000_0000));
    check("single_cnt1", 128'(outstanding), 128'(1));
    m_ready = 1'b1;
    step();
    set_status(8'h23, 4'h0);
    step();
    check("single_strobe", 128'(o_st_valid), 128'(2'b10));
    check("single_stag", 128'(o_st_tag[STW +: STW]), 128'(5'd3));
    check("single_cnt0", 128'(outstanding), 128'(0));

    // Fairness and the in-flight limit
    s_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair_order", 128'(obs_ready), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    step();
    check("limit_ready", 128'(obs_ready), 128'(2'b00));
    check("limit_cnt", 128'(outstanding), 128'(4));
    set_status(inflight[0], 4'h0);
    step();
    check("limit_same_cycle", 128'(obs_ready), 128'(2'b00));
    step();
    check("limit_next_cycle", 128'(obs_ready), 128'(2'b01));
    s_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_status(inflight[0], 4'h0);
      step();
    end
    check("drain_cnt", 128'(outstanding), 128'(0));

    // Backpressure
    m_ready = 1'b0;
    s_valid = 2'b11;
    step();
    check("bp_first", 128'(obs_ready), 128'(2'b10));
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_ready", 128'(obs_ready), 128'(2'b00));
      check("bp_tag", 128'(m_tag), 128'(8'h23));
      check("bp_len", 128'(m_len), 128'(20'h00400));
    end
    m_ready = 1'b1;
    step();
    check("bp_release", 128'(obs_ready), 128'(2'b01));

    // Grant and completion in the same cycle at count 2
    s_valid = 2'b10;
    set_status(inflight[0], 4'h0);
    step();
    check("simul_cnt", 128'(outstanding), 128'(2));
    s_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      set_status(inflight[0], 4'h0);
      step();
    end

    // Unexpected completions
    set_status(8'h60, 4'h5);
    step();
    check("bad_port_strobe", 128'(o_st_valid), 128'(2'b00));
    check("bad_port_flag", 128'(unexpected), 128'(1));
    set_status(8'h23, 4'h7);
    step();
    check("zero_cnt_strobe", 128'(o_st_valid), 128'(2'b10));
    check("zero_cnt_err", 128'(o_st_err[4 +: 4]), 128'(4'h7));
    check("zero_cnt_cnt", 128'(outstanding), 128'(0));
    do_reset();
    check("rst_flag", 128'(unexpected), 128'(0));

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      s_valid = PORTS'($urandom_range(0, (1 << PORTS) - 1));
      if ($urandom_range(0, 3) == 0) begin
        s_addr = (PORTS*AW)'({$urandom, $urandom, $urandom});
        s_len  = (PORTS*LW)'({$urandom, $urandom});
        s_tag  = (PORTS*STW)'($urandom);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        set_status(inflight[$urandom_range(0, inflight.size() - 1)], 4'($urandom));
      end else if ($urandom_range(0, 39) == 0) begin
        set_status(DTW'($urandom), 4'($urandom));
      end
      if (c == 200) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
